// File: rtl/bitsim_codec_pkg.sv
// bitsim_codec_pkg: shared widths, decoder states and popcount for the bit-serial codec.
package bitsim_codec_pkg;
    localparam int MASK_W = 16;
    localparam int IDX_W = 4;
    typedef enum logic [1:0] {IDLE, ACC, PEND} dec_state_t;
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/p_decoder_4to16_module_if.sv
// p_decoder_4to16_module_if: index-beat input stream and assembled-word output stream.
interface p_decoder_4to16_module_if;
    import bitsim_codec_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [IDX_W-1:0]  in_idx;
    logic              in_zero;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [MASK_W-1:0] out_mask;
    logic [4:0]        out_count;
    logic              dup_err;
    modport master (output in_valid, in_idx, in_zero, in_last, out_ready,
                    input in_ready, out_valid, out_mask, out_count, dup_err);
    modport slave (input in_valid, in_idx, in_zero, in_last, out_ready,
                   output in_ready, out_valid, out_mask, out_count, dup_err);
endinterface

// File: rtl/p_decoder_4to16.sv
// p_decoder_4to16: index to one-hot mask, index 0 maps to the MSB (encoder order).
module p_decoder_4to16
    import bitsim_codec_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    output logic [MASK_W-1:0] onehot_o
);
    assign onehot_o = {1'b1, {(MASK_W-1){1'b0}}} >> idx_i;
endmodule

// File: rtl/p_decoder_4to16_module.sv
// p_decoder_4to16_module: rebuilds essential-bit masks and popcounts from index beats,
// with an accumulator plus output register acting as a one-word skid.
module p_decoder_4to16_module #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input logic clk,
    input logic reset,
    p_decoder_4to16_module_if.slave bus
);
    import bitsim_codec_pkg::*;
    if (WIDTH != MASK_W || IDX_W != $clog2(WIDTH)) begin : g_bad_width
        $error("p_decoder_4to16_module supports only a 16-bit mask");
    end
    dec_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_mask_q, out_mask_d;
    logic [4:0]       out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;
    logic             dup_q, dup_d;
    logic [WIDTH-1:0] onehot, new_bit, merged;
    logic             fire, slot_free;
    p_decoder_4to16 u_dec (
        .idx_i    (bus.in_idx),
        .onehot_o (onehot)
    );
    assign new_bit   = bus.in_zero ? '0 : onehot;
    assign merged    = acc_q | new_bit;
    assign fire      = bus.in_valid & (state_q != PEND);
    assign slot_free = !out_valid_q | bus.out_ready;
    // A zero beat without last falls out naturally as a non-last beat with no bit set.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_mask_d  = out_mask_q;
        out_count_d = out_count_q;
        dup_d       = 1'b0;
        if (state_q == PEND) begin
            if (slot_free) begin
                out_valid_d = 1'b1;
                out_mask_d  = acc_q;
                out_count_d = popcount16(acc_q);
                acc_d       = '0;
                state_d     = IDLE;
            end
        end else if (fire) begin
            dup_d = |(acc_q & new_bit);
            if (!bus.in_last) begin
                acc_d   = merged;
                state_d = ACC;
            end else if (slot_free) begin
                out_valid_d = 1'b1;
                out_mask_d  = merged;
                out_count_d = popcount16(merged);
                acc_d       = '0;
                state_d     = IDLE;
            end else begin
                acc_d   = merged;
                state_d = PEND;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_count_q <= '0;
            dup_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_count_q <= out_count_d;
            dup_q       <= dup_d;
        end
    end
    assign bus.in_ready  = (state_q != PEND);
    assign bus.out_valid = out_valid_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_count = out_count_q;
    assign bus.dup_err   = dup_q;
endmodule

// File: tb/tb_p_decoder_4to16_module.sv
// tb_p_decoder_4to16_module: scoreboard bench; expected words are queued as beats are
// driven and compared when the consumer handshakes them off the output.
module tb_p_decoder_4to16_module;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_dup = 0;
    logic [15:0] m_acc = '0;
    logic [20:0] sb_q[$];
    p_decoder_4to16_module_if bus ();
    p_decoder_4to16_module dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [3:0] idx, input logic z, input logic l);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_idx   = idx;
        bus.in_zero  = z;
        bus.in_last  = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        if (!z) m_acc = m_acc | (16'h8000 >> idx);
        if (l) begin
            sb_q.push_back({5'($countones(m_acc)), m_acc});
            m_acc = '0;
        end
    endtask
    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_zero  = 1'b0;
        bus.in_last  = 1'b0;
    endtask
    always @(negedge clk) begin
        if (reset) begin
            if (bus.dup_err) n_dup++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    logic [20:0] e;
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("word_mask", 32'(bus.out_mask), 32'(e[15:0]));
                    chk("word_count", 32'(bus.out_count), 32'(e[20:16]));
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        bus.in_idx = '0;
        bus.out_ready = 1'b1;
        idle();
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_dup_err", 32'(bus.dup_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(4'd0, 1'b0, 1'b0);
        send(4'd3, 1'b0, 1'b0);
        send(4'd15, 1'b0, 1'b1);
        idle();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_mask", 32'(bus.out_mask), 32'h9001);
        chk("t1_count", 32'(bus.out_count), 32'd3);
        @(posedge clk);
        #1;
        chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);
        send(4'd7, 1'b1, 1'b1);
        idle();
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_mask", 32'(bus.out_mask), 32'h0000);
        send(4'd5, 1'b0, 1'b0);
        send(4'd5, 1'b0, 1'b1);
        idle();
        chk("t3_dup_pulse", 32'(bus.dup_err), 32'd1);
        chk("t3_mask", 32'(bus.out_mask), 32'h0400);
        chk("t3_count", 32'(bus.out_count), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_dup_drop", 32'(bus.dup_err), 32'd0);
        bus.out_ready = 1'b0;
        send(4'd0, 1'b0, 1'b1);
        chk("t4_a_held", 32'(bus.out_mask), 32'h8000);
        send(4'd1, 1'b0, 1'b1);
        idle();
        chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t4_a_still", 32'(bus.out_mask), 32'h8000);
        @(posedge clk);
        #1;
        chk("t4_pend_hold", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("t4_ready_not_comb", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_b_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_b_mask", 32'(bus.out_mask), 32'h4000);
        chk("t4_in_ready_back", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(4'(i), 1'b0, 1'b1);
            chk("t5_no_bubble", 32'(bus.out_valid), 32'd1);
            chk("t5_mask", 32'(bus.out_mask), 32'h8000 >> i);
        end
        idle();
        @(posedge clk);
        #1;
        send(4'd2, 1'b0, 1'b0);
        send(4'd7, 1'b0, 1'b0);
        idle();
        #2;
        reset = 1'b0;
        m_acc = '0;
        #1;
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_out_mask", 32'(bus.out_mask), 32'd0);
        chk("t6_out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(4'd9, 1'b0, 1'b1);
        idle();
        chk("t6_clean_mask", 32'(bus.out_mask), 32'h0040);
        chk("t6_clean_count", 32'(bus.out_count), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("words_seen", 32'(n_pop), 32'd22);
        chk("dup_pulses", 32'(n_dup), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
